// File: rtl/vga_pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the video-domain reset; retries on lock timeout and parks in FAIL.
module vga_pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       video_reset_n,
  output logic [2:0] state,
  output logic [2:0] retry_count,
  output logic [7:0] relock_count,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_ASSERT_RST = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_RUN        = 3'd3,
    S_FAIL       = 3'd4
  } state_e;

  // Each counter only needs to reach its terminal value (N-1).
  localparam int unsigned RW = (RESET_CYCLES > 1)        ? $clog2(RESET_CYCLES)        : 1;
  localparam int unsigned SW = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;
  localparam int unsigned TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRIES);

  logic [1:0]    sync_q;
  logic          locked_s;
  state_e        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]    retry_q, retry_d, retry_inc;
  logic [7:0]    relock_q, relock_d;
  logic          pll_rst_q, video_q, fail_q;
  logic          attempt_end;

  assign locked_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    to_cnt_d    = to_cnt_q;
    retry_d     = retry_q;
    relock_d    = relock_q;
    attempt_end = 1'b0;
    retry_inc   = retry_q + 3'd1;

    case (state_q)
      S_ASSERT_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_WAIT_LOCK;
          rst_cnt_d = '0;
          to_cnt_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (to_cnt_q == TO_LAST) begin
          attempt_end = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (locked_s) begin
            state_d   = S_STABLE;
            stb_cnt_d = '0;
          end
        end
      end
      S_STABLE: begin
        // A completed stability window beats a timeout landing on the same cycle.
        if (locked_s && stb_cnt_q == STB_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          attempt_end = 1'b1;
        end else if (!locked_s) begin
          state_d   = S_WAIT_LOCK;
          stb_cnt_d = '0;
          to_cnt_d  = to_cnt_q + 1'b1;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
          to_cnt_d  = to_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d   = S_ASSERT_RST;
          rst_cnt_d = '0;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d   = S_ASSERT_RST;
        rst_cnt_d = '0;
      end
    endcase

    if (attempt_end) begin
      retry_d   = retry_inc;
      rst_cnt_d = '0;
      state_d   = (retry_inc == RETRY_MAX) ? S_FAIL : S_ASSERT_RST;
    end

    if (force_relock) begin
      state_d   = S_ASSERT_RST;
      rst_cnt_d = '0;
      retry_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b00;
      state_q   <= S_ASSERT_RST;
      rst_cnt_q <= '0;
      stb_cnt_q <= '0;
      to_cnt_q  <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      video_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pll_locked};
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      to_cnt_q  <= to_cnt_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      pll_rst_q <= (state_d == S_ASSERT_RST);
      video_q   <= (state_d == S_RUN);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign state         = state_q;
  assign pll_rst       = pll_rst_q;
  assign video_reset_n = video_q;
  assign fail          = fail_q;
  assign retry_count   = retry_q;
  assign relock_count  = relock_q;

endmodule

// File: tb/tb_vga_pll_reset_sequencer.sv
// Bench for vga_pll_reset_sequencer: table of multi-cycle vectors with hand-derived
// expected outputs, queued as they are driven and compared after the last edge.
module tb_vga_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, video_reset_n, fail;
  logic [2:0] state, retry_count;
  logic [7:0] relock_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    int         n;
    bit         lk;
    bit         frc;
    logic [2:0] st;
    bit         prst;
    bit         vrn;
    logic [2:0] rty;
    logic [7:0] rlk;
    bit         fl;
  } vec_t;

  typedef struct {
    string       name;
    logic [16:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  vga_pll_reset_sequencer #(
    .RESET_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .force_relock(force_relock),
    .pll_rst(pll_rst),
    .video_reset_n(video_reset_n),
    .state(state),
    .retry_count(retry_count),
    .relock_count(relock_count),
    .fail(fail)
  );

  function automatic vec_t mk(input string name, input int n, input bit lk, input bit frc,
                              input int st, input bit prst, input bit vrn, input int rty,
                              input int rlk, input bit fl);
    vec_t v;
    v.name = name; v.n = n; v.lk = lk; v.frc = frc;
    v.st = 3'(st); v.prst = prst; v.vrn = vrn;
    v.rty = 3'(rty); v.rlk = 8'(rlk); v.fl = fl;
    return v;
  endfunction

  task automatic compare_front();
    exp_t        e;
    logic [16:0] act;
    e   = sb_q.pop_front();
    act = {state, pll_rst, video_reset_n, retry_count, relock_count, fail};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s: got state=%0d pll_rst=%0b vrn=%0b retry=%0d relock=%0d fail=%0b, want state=%0d pll_rst=%0b vrn=%0b retry=%0d relock=%0d fail=%0b",
               e.name, act[16:14], act[13], act[12], act[11:9], act[8:1], act[0],
               e.exp[16:14], e.exp[13], e.exp[12], e.exp[11:9], e.exp[8:1], e.exp[0]);
    end else begin
      $display("check %s ok: state=%0d retry=%0d relock=%0d", e.name, act[16:14], act[11:9], act[8:1]);
    end
  endtask

  task automatic check_now(input string name, input logic [16:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    compare_front();
  endtask

  // Drive one vector for v.n cycles (force only on the first), then compare.
  task automatic apply(input vec_t v);
    exp_t e;
    for (int c = 0; c < v.n; c++) begin
      pll_locked   = v.lk;
      force_relock = (c == 0) ? v.frc : 1'b0;
      if (c == 0) begin
        e.name = v.name;
        e.exp  = {v.st, v.prst, v.vrn, v.rty, v.rlk, v.fl};
        sb_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      force_relock = 1'b0;
      checks++;
      if ((pll_rst && state != 3'd0) || (video_reset_n && state != 3'd3)) begin
        errors++;
        $display("FAIL invariant in %s: state=%0d pll_rst=%0b vrn=%0b", v.name, state, pll_rst, video_reset_n);
      end
    end
    compare_front();
  endtask

  initial begin
    int k;
    // Nominal lock 10 cycles after reset release.
    tbl.push_back(mk("rst_cyc1",        1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("rst_cyc3",        2, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("wait_entry",      1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("wait_nolock",     5, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sync_lat",        2, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("stable_entry",    1, 1, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("stable_last",     7, 1, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("run_entry",       1, 1, 0, 3, 0, 1, 0, 0, 0));
    tbl.push_back(mk("run_hold",        5, 1, 0, 3, 0, 1, 0, 0, 0));
    // Lock loss in RUN: 3-cycle latency, relock counted, 4-cycle pll_rst.
    tbl.push_back(mk("loss_sync",       2, 0, 0, 3, 0, 1, 0, 0, 0));
    tbl.push_back(mk("loss_enter",      1, 0, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("loss_pulse",      3, 0, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("loss_wait",       1, 0, 0, 1, 0, 0, 0, 1, 0));
    // Three timed-out attempts into FAIL.
    tbl.push_back(mk("to1_last",       31, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("to1_end",         1, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk("to1_pulse",       3, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk("to2_wait",        1, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk("to2_end",        32, 0, 0, 0, 1, 0, 2, 1, 0));
    tbl.push_back(mk("to3_wait",        4, 0, 0, 1, 0, 0, 2, 1, 0));
    tbl.push_back(mk("to3_last",       31, 0, 0, 1, 0, 0, 2, 1, 0));
    tbl.push_back(mk("fail_entry",      1, 0, 0, 4, 0, 0, 3, 1, 1));
    tbl.push_back(mk("fail_hold",      20, 0, 0, 4, 0, 0, 3, 1, 1));
    tbl.push_back(mk("fail_lock",      10, 1, 0, 4, 0, 0, 3, 1, 1));
    // Force out of FAIL, then a one-cycle glitch at stable count 5.
    tbl.push_back(mk("force_fail",      1, 1, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("force_pulse",     3, 1, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("force_wait",      1, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("force_stable",    1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("glitch_pre",      3, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("glitch_drop",     1, 0, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("glitch_sync",     1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("glitch_wait",     1, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("glitch_restable", 1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("glitch_count",    7, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("glitch_run",      1, 1, 0, 3, 0, 1, 0, 1, 0));
    // Force from RUN; stable completion coincides with timeout -> RUN.
    tbl.push_back(mk("force_run",       1, 0, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("tie_wait",       19, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_lock",        2, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_stable",      1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_pre",         2, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_drop",        1, 0, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_sync",        1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_back",        1, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_restable",    1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_count",       7, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("tie_run",         1, 1, 0, 3, 0, 1, 0, 1, 0));
    // Same shape shifted one cycle: timeout survives the STABLE->WAIT bounce.
    tbl.push_back(mk("nr_force",        1, 0, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("nr_wait",        20, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_lock",         2, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_stable",       1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_pre",          2, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_drop",         1, 0, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_sync",         1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_back",         1, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_restable",     1, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_count",        6, 1, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nr_timeout",      1, 1, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk("nr_recover",     12, 1, 0, 2, 0, 0, 1, 1, 0));
    tbl.push_back(mk("nr_run",          1, 1, 0, 3, 0, 1, 0, 1, 0));

    // Asynchronous reset assertion, before any clock edge.
    #2 reset_n = 1'b0;
    #1 check_now("reset_async", {3'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0});
    repeat (2) @(negedge clk);
    check_now("reset_held", {3'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0});
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // 256 lock losses from RUN; relock_count must saturate at 255.
    for (int i = 0; i < 256; i++) begin
      k = (i + 2 > 255) ? 255 : i + 2;
      apply(mk("sat_loss", 3, 0, 0, 0, 1, 0, 0, k, 0));
      apply(mk("sat_run", 13, 1, 0, 3, 0, 1, 0, k, 0));
    end

    // Reset pulse mid-STABLE, then a clean restart from scratch.
    apply(mk("sat_force",     1, 1, 1, 0, 1, 0, 0, 255, 0));
    apply(mk("mid_stable",    7, 1, 0, 2, 0, 0, 0, 255, 0));
    #2 reset_n = 1'b0;
    #1 check_now("reset_mid", {3'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk("rel_wait",      4, 1, 0, 1, 0, 0, 0, 0, 0));
    apply(mk("rel_stable",    1, 1, 0, 2, 0, 0, 0, 0, 0));
    apply(mk("rel_run",       8, 1, 0, 3, 0, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
